// File: rtl/test_port_writer.sv
// Test-port result writer: emits BEGIN_SYM, NUM_WORDS FIFO-buffered result words, then END_SYM
// as single-cycle little-endian word writes to TEST_PORT, with an idle gap after each commit.
module test_port_writer #(
    parameter logic [29:0] TEST_PORT = 30'hFF,
    parameter logic [31:0] BEGIN_SYM = 32'h00000168,
    parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
    parameter int          NUM_WORDS = 6,
    parameter int          DEPTH     = 8,
    parameter int          GAP       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    input  logic        stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [7:0]  words_sent
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEGIN,
        S_GAP,
        S_DATA,
        S_END,
        S_DONE
    } state_t;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    state_t      state, state_n;
    logic [7:0]  gap_cnt, gap_n;
    logic [7:0]  words_n;
    logic [29:0] addr_n;
    logic [31:0] data_n;
    logic        wen_n, busy_n, done_n;

    assign res_ready = (count != CW'(DEPTH));
    assign push      = res_valid && res_ready;

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state and next-output logic; a write is issued by loading the output register,
    // and a commit (wen && !stall) clears it and starts the idle gap.
    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        words_n = words_sent;
        addr_n  = addr;
        data_n  = data;
        wen_n   = wen;
        pop     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_BEGIN;
                    words_n = '0;
                end
            end
            S_BEGIN: begin
                if (!wen) begin
                    wen_n  = 1'b1;
                    addr_n = TEST_PORT;
                    data_n = swap(BEGIN_SYM);
                end else if (!stall) begin
                    wen_n   = 1'b0;
                    addr_n  = '0;
                    data_n  = '0;
                    gap_n   = 8'(GAP - 1);
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt != 8'd0) begin
                    gap_n = gap_cnt - 8'd1;
                end else if (words_sent < 8'(NUM_WORDS)) begin
                    state_n = S_DATA;
                    if (count != '0) begin
                        pop    = 1'b1;
                        wen_n  = 1'b1;
                        addr_n = TEST_PORT;
                        data_n = swap(mem[rd_ptr]);
                    end
                end else begin
                    state_n = S_END;
                    wen_n   = 1'b1;
                    addr_n  = TEST_PORT;
                    data_n  = swap(END_SYM);
                end
            end
            S_DATA: begin
                if (!wen) begin
                    if (count != '0) begin
                        pop    = 1'b1;
                        wen_n  = 1'b1;
                        addr_n = TEST_PORT;
                        data_n = swap(mem[rd_ptr]);
                    end
                end else if (!stall) begin
                    wen_n   = 1'b0;
                    addr_n  = '0;
                    data_n  = '0;
                    words_n = words_sent + 8'd1;
                    gap_n   = 8'(GAP - 1);
                    state_n = S_GAP;
                end
            end
            S_END: begin
                if (!wen) begin
                    wen_n  = 1'b1;
                    addr_n = TEST_PORT;
                    data_n = swap(END_SYM);
                end else if (!stall) begin
                    wen_n   = 1'b0;
                    addr_n  = '0;
                    data_n  = '0;
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            words_sent <= '0;
            addr       <= '0;
            data       <= '0;
            wen        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_n;
            words_sent <= words_n;
            addr       <= addr_n;
            data       <= data_n;
            wen        <= wen_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_test_port_writer.sv
// Directed testbench for test_port_writer: table-driven result words plus hand-written
// sequences for stall hold, empty-FIFO waits, FIFO full, mid-sequence reset and ignored start.
module tb_test_port_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic        res_ready;
    logic        stall = 1'b0;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        busy;
    logic        done;
    logic [7:0]  words_sent;

    int tests = 0;
    int fails = 0;

    logic [31:0] commits [$];
    logic [31:0] exp_q [$];
    logic        last_commit = 1'b0;
    logic        last_stalled = 1'b0;
    logic [31:0] last_data = '0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] swapped;
    } vec_t;
    vec_t vecs [6];

    test_port_writer dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .res_valid(res_valid),
        .res_data(res_data),
        .res_ready(res_ready),
        .stall(stall),
        .addr(addr),
        .data(data),
        .wen(wen),
        .busy(busy),
        .done(done),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: records committed words and checks address, gap and stall hold.
    always @(negedge clk) begin
        if (rst) begin
            last_commit  = 1'b0;
            last_stalled = 1'b0;
        end else begin
            if (last_commit) check("gap_wen", {31'd0, wen}, 32'd0);
            if (last_stalled) begin
                check("hold_wen", {31'd0, wen}, 32'd1);
                check("hold_data", data, last_data);
            end
            if (wen) check("addr", {2'b00, addr}, 32'h000000FF);
            if (wen && !stall) commits.push_back(data);
            last_commit  = wen && !stall;
            last_stalled = wen && stall;
            last_data    = data;
        end
    end

    task automatic push_word(input logic [31:0] w);
        res_valid = 1'b1;
        res_data  = w;
        step();
        res_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic begin_exp();
        exp_q = {};
        exp_q.push_back(32'h68010000);
    endtask

    task automatic checkOutput(input string name);
        exp_q.push_back(32'h5DFDFFFF);
        check({name, "_count"}, commits.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i),
                  (i < commits.size()) ? commits[i] : 32'hXXXXXXXX, exp_q[i]);
        end
        check({name, "_words_sent"}, {24'd0, words_sent}, 32'd6);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        commits = {};
    endtask

    task automatic applyStimulus();
        int n;
        // Reset state
        step();
        step();
        check("rst_wen", {31'd0, wen}, 32'd0);
        check("rst_addr", {2'b00, addr}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_words", {24'd0, words_sent}, 32'd0);
        check("rst_ready", {31'd0, res_ready}, 32'd1);
        rst = 1'b0;
        step();

        // Table-driven basic sequence with start latency check
        begin_exp();
        for (int i = 0; i < 6; i++) begin
            push_word(vecs[i].word);
            exp_q.push_back(vecs[i].swapped);
        end
        pulse_start();
        check("lat_wen0", {31'd0, wen}, 32'd0);
        check("lat_busy", {31'd0, busy}, 32'd1);
        step();
        check("lat_wen1", {31'd0, wen}, 32'd1);
        check("lat_data", data, 32'h68010000);
        wait_done("basic");
        checkOutput("basic");

        // Stall during BEGIN write
        begin_exp();
        for (int i = 0; i < 6; i++) begin
            push_word(32'hC0DE0000 + i);
            exp_q.push_back(swap(32'hC0DE0000 + i));
        end
        pulse_start();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_wen%0d", i), {31'd0, wen}, 32'd1);
            check($sformatf("stall_data%0d", i), data, 32'h68010000);
        end
        stall = 1'b0;
        check("stall_nocommit", commits.size(), 32'd0);
        wait_done("stall");
        checkOutput("stall");

        // Empty FIFO: writer waits in DATA for each late word
        begin_exp();
        pulse_start();
        for (int i = 0; i < 8; i++) step();
        check("empty_wen", {31'd0, wen}, 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd1);
        check("empty_words", {24'd0, words_sent}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            push_word(32'h11223300 + i);
            exp_q.push_back(swap(32'h11223300 + i));
            for (int j = 0; j < 4; j++) step();
        end
        wait_done("empty");
        checkOutput("empty");

        // FIFO full: 9th word refused and lost
        for (int i = 0; i < 9; i++) begin
            check($sformatf("full_ready%0d", i), {31'd0, res_ready}, (i < 8) ? 32'd1 : 32'd0);
            push_word(32'hF0000000 + i);
        end
        check("full_ready_end", {31'd0, res_ready}, 32'd0);
        begin_exp();
        for (int i = 0; i < 6; i++) exp_q.push_back(swap(32'hF0000000 + i));
        pulse_start();
        wait_done("full1");
        checkOutput("full1");
        begin_exp();
        exp_q.push_back(swap(32'hF0000006));
        exp_q.push_back(swap(32'hF0000007));
        for (int i = 0; i < 4; i++) begin
            push_word(32'hE0000000 + i);
            exp_q.push_back(swap(32'hE0000000 + i));
        end
        pulse_start();
        wait_done("full2");
        checkOutput("full2");

        // Reset mid-DATA after three words
        for (int i = 0; i < 6; i++) push_word(32'hBAD00000 + i);
        pulse_start();
        n = 0;
        while (words_sent != 8'd3 && n < 200) begin
            step();
            n++;
        end
        check("mid_reached3", {24'd0, words_sent}, 32'd3);
        rst = 1'b1;
        step();
        check("mid_wen", {31'd0, wen}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_ready", {31'd0, res_ready}, 32'd1);
        check("mid_words", {24'd0, words_sent}, 32'd0);
        rst = 1'b0;
        commits = {};
        for (int i = 0; i < 5; i++) step();
        check("mid_idle", commits.size(), 32'd0);
        begin_exp();
        for (int i = 0; i < 6; i++) begin
            push_word(32'h0000A000 + i);
            exp_q.push_back(swap(32'h0000A000 + i));
        end
        pulse_start();
        wait_done("rerun");
        checkOutput("rerun");

        // start while busy is ignored
        begin_exp();
        for (int i = 0; i < 6; i++) begin
            push_word(32'h5A5A0000 + i);
            exp_q.push_back(swap(32'h5A5A0000 + i));
        end
        pulse_start();
        step();
        pulse_start();
        for (int i = 0; i < 4; i++) step();
        pulse_start();
        wait_done("ignore");
        for (int i = 0; i < 20; i++) step();
        check("ignore_still_done", {31'd0, done}, 32'd1);
        checkOutput("ignore");
    endtask

    initial begin
        vecs[0] = '{word: 32'h00000000, swapped: 32'h00000000};
        vecs[1] = '{word: 32'h00000001, swapped: 32'h01000000};
        vecs[2] = '{word: 32'h12345678, swapped: 32'h78563412};
        vecs[3] = '{word: 32'hDEADBEEF, swapped: 32'hEFBEADDE};
        vecs[4] = '{word: 32'hA5A50F0F, swapped: 32'h0F0FA5A5};
        vecs[5] = '{word: 32'hFFFFFFFF, swapped: 32'hFFFFFFFF};
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
